// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to a
// wait-state-capable instruction memory and buffers returned words in a prefetch queue.
module fetch_unit #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallD,
  input  logic             BranchTakenE,
  input  logic [WIDTH-1:0] BranchTargetE,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus8D,
  output logic             ValidD
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pcf;
  logic [WIDTH-1:0] q_instr [DEPTH];
  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Request never looks at StallD, keeping decode stalls off the memory path.
  assign imem_req  = !reset && !BranchTakenE && (count < CW'(DEPTH));
  assign imem_addr = pcf;
  assign push      = imem_req && imem_ready;
  assign pop       = ValidD && !StallD;

  assign ValidD   = (count != '0);
  assign InstrD   = ValidD ? q_instr[rd_ptr] : '0;
  assign PCPlus8D = ValidD ? (q_pc[rd_ptr] + WIDTH'(8)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (BranchTakenE) begin
      pcf    <= {BranchTargetE[WIDTH-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pcf    <= pcf + WIDTH'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= pcf;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference queue model acts as scoreboard,
// plus directed checks at the interesting points of each scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        chk_en;
  logic [31:0] popped[$];

  always #5 clk = ~clk;

  // Memory image: word at address a holds a+1 (mem[i] = i*4+1).
  assign imem_rdata = imem_addr + 32'd1;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .BranchTakenE(BranchTakenE),
    .BranchTargetE(BranchTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD),
    .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_pc8;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e_req   = !reset && !BranchTakenE && (mq.size() < 2);
      e_valid = (mq.size() != 0);
      e_instr = e_valid ? mq[0].instr : 32'h0;
      e_pc8   = e_valid ? mq[0].pc + 32'd8 : 32'h0;
      if (chk_en) begin
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("ValidD", {31'b0, ValidD}, {31'b0, e_valid});
        chk("InstrD", InstrD, e_instr);
        chk("PCPlus8D", PCPlus8D, e_pc8);
      end
      if (reset) begin
        m_pc = 32'h0;
        mq.delete();
      end else if (BranchTakenE) begin
        m_pc = {BranchTargetE[31:2], 2'b00};
        mq.delete();
      end else begin
        if (e_valid && !StallD) begin
          popped.push_back(mq[0].instr);
          void'(mq.pop_front());
        end
        if (e_req && imem_ready) begin
          mq.push_back('{instr: m_pc + 32'd1, pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; BranchTakenE = 1'b0;
    BranchTargetE = 32'h0; imem_ready = 1'b1;
    chk_en = 1'b0; m_pc = 32'h0;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", InstrD, 32'h0);

    // Streaming with zero wait states
    reset = 1'b0;
    step(1);
    chk("first_instr", InstrD, 32'h1);
    chk("first_pc8", PCPlus8D, 32'h8);
    chk("first_addr", imem_addr, 32'h4);
    step(1);
    chk("second_instr", InstrD, 32'h5);

    // Decode stall fills the queue and freezes the head
    popped.delete();
    StallD = 1'b1;
    step(5);
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    chk("stall_head", InstrD, 32'h5);
    StallD = 1'b0;
    step(3);
    chk("stall_pop0", popped[0], 32'h5);
    chk("stall_pop1", popped[1], 32'h9);
    chk("stall_pop2", popped[2], 32'hd);

    // Wait states
    imem_ready = 1'b0;
    step(3);
    chk("wait_addr", imem_addr, m_pc);
    imem_ready = 1'b1;
    step(3);

    // Redirect with full queue, memory ready
    StallD = 1'b1;
    step(3);
    chk("pre_br_valid", {31'b0, ValidD}, 32'h1);
    BranchTakenE = 1'b1; BranchTargetE = 32'h0000_0103;
    step(1);
    BranchTakenE = 1'b0; StallD = 1'b0;
    chk("br_valid", {31'b0, ValidD}, 32'h0);
    chk("br_addr", imem_addr, 32'h0000_0100);
    step(1);
    chk("br_first", InstrD, 32'h0000_0101);
    step(2);

    // Address wrap at the top of memory
    BranchTakenE = 1'b1; BranchTargetE = 32'hFFFF_FFFC;
    step(1);
    BranchTakenE = 1'b0;
    step(1);
    chk("wrap_instr", InstrD, 32'hFFFF_FFFD);
    chk("wrap_pc8", PCPlus8D, 32'h0000_0004);
    chk("wrap_addr", imem_addr, 32'h0);
    step(2);

    // Reset beats redirect
    reset = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h0000_0200;
    step(1);
    reset = 1'b0; BranchTakenE = 1'b0;
    chk("rstbr_valid", {31'b0, ValidD}, 32'h0);
    chk("rstbr_addr", imem_addr, 32'h0);
    step(2);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      StallD        = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      BranchTakenE  = ($urandom_range(0, 19) == 0);
      BranchTargetE = $urandom;
      reset         = ($urandom_range(0, 99) == 0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
